rom_fetch_sequencer: RTL and testbench

Sequences each instruction fetch for the 4-bit core from an off-chip parallel ROM. It walks the core's muxed 5-bit PC output through its two halves, assembles the 10-bit address, and runs a req/ack handshake with the ROM. It returns one instruction byte per fetch, inserting a NOP byte on timeout. It sits between the core's PC_HL/PC_MUX pins and the ROM byte bus, replacing the free-running external mux.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_wait_timer.sv | 15 +
 rtl/rom_fetch_sequencer.sv | 67 ++++++
 tb/tb_rom_fetch_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP opcode and fetch FSM state encoding
package fetch_pkg;
  localparam int PC_W = 10;
  localparam int HALF_W = 5;
  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] NOP_OPCODE = 8'h00;
  typedef enum logic [2:0] {IDLE, HI, LO, REQ, DONE} state_e;
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: 4-bit saturating wait counter (clk, rst, clr_i, en_i in; expired_o high once the current REQ cycle is the last allowed)
module fetch_wait_timer #(
  parameter int WAIT_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 4'd0 : (en_i && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
  assign expired_o = cnt_q >= 4'(WAIT_MAX - 1);
endmodule

// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer: walks core PC halves, builds the ROM address, runs req/ack and returns one byte per fetch (NOP on timeout); ports per interface list
module rom_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WAIT_MAX = 4,
  parameter logic [INSTR_W-1:0] NOP_BYTE = NOP_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               cyc_start,
  input  logic [HALF_W-1:0]  pc_hl,
  output logic               pc_mux,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic               overrun_err,
  input  logic               err_clr
);
  state_e state_q, state_d;
  logic expired, tmo_set, ovr_set;
  fetch_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(ena && state_q == LO),
    .en_i(ena && state_q == REQ && !rom_ack),
    .expired_o(expired)
  );
  // ack on the final allowed cycle still counts as success
  assign tmo_set = state_q == REQ && !rom_ack && expired;
  assign ovr_set = cyc_start && state_q != IDLE;
  always_comb
    state_d = state_q == IDLE ? (cyc_start ? HI : IDLE) :
              state_q == HI   ? LO :
              state_q == LO   ? REQ :
              state_q == REQ  ? ((rom_ack || expired) ? DONE : REQ) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_mux      <= 1'b0;
      rom_addr    <= '0;
      rom_req     <= 1'b0;
      instr       <= NOP_BYTE;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      pc_mux      <= state_d == HI;
      rom_req     <= state_d == REQ;
      instr_valid <= state_d == DONE;
      busy        <= state_d != IDLE;
      if (state_q == HI) rom_addr[PC_W-1:HALF_W] <= pc_hl;
      if (state_q == LO) rom_addr[HALF_W-1:0] <= pc_hl;
      if (state_q == REQ && rom_ack) instr <= rom_data;
      else if (tmo_set) instr <= NOP_BYTE;
      timeout_err <= tmo_set || (timeout_err && !err_clr);
      overrun_err <= ovr_set || (overrun_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb_rom_fetch_sequencer: scoreboard bench with ROM responder and random fetches
module tb_rom_fetch_sequencer;
  localparam int W = 4;
  typedef struct {
    logic [9:0] addr;
    logic [7:0] instr;
    bit tmo;
    bit ovr;
    int start;
    int lat;
    int reqs;
  } exp_t;
  logic clk, rst, ena, cyc_start, pc_mux, rom_req, rom_ack, instr_valid, busy, timeout_err, overrun_err, err_clr;
  logic [4:0] pc_hl;
  logic [9:0] rom_addr, cur_pc;
  logic [7:0] rom_data, instr;
  logic [7:0] mem [1024];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, ack_delay = 0;

  rom_fetch_sequencer #(.WAIT_MAX(W), .NOP_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cyc_start(cyc_start), .pc_hl(pc_hl),
    .pc_mux(pc_mux), .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr(instr), .instr_valid(instr_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  assign pc_hl = pc_mux ? cur_pc[9:5] : cur_pc[4:0];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ROM: acks after ack_delay active REQ cycles; random noise on ack/data outside REQ
  initial begin
    int rc = 0;
    rom_ack = 0;
    rom_data = 0;
    forever begin
      @(negedge clk);
      if (!ena) rom_ack = 0;
      else if (rom_req) begin
        rom_ack = (rc == ack_delay);
        rom_data = rom_ack ? mem[rom_addr] : 8'($urandom);
        rc++;
      end else begin
        rc = 0;
        rom_ack = 1'($urandom);
        rom_data = 8'($urandom);
      end
    end
  end

  // monitor: pops the scoreboard on every instr_valid
  initial begin
    int reqs = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) reqs = 0;
      else if (ena) begin
        if (rom_req) reqs++;
        if (instr_valid) begin
          if (sb.size() == 0) chk("no_spurious_valid", instr_valid, 0);
          else begin
            e = sb.pop_front();
            chk("instr", instr, e.instr);
            chk("rom_addr", rom_addr, e.addr);
            chk("timeout_err", timeout_err, e.tmo);
            chk("overrun_err", overrun_err, e.ovr);
            chk("latency", cyc - e.start, e.lat);
            chk("req_cycles", reqs, e.reqs);
            chk("busy_in_done", busy, 1);
          end
          reqs = 0;
        end
      end
    end
  end

  task automatic fetch(input logic [9:0] pc, input int d, input bit push, input bit ovr, input int extra);
    exp_t e;
    cur_pc = pc;
    ack_delay = d;
    e.addr = pc;
    e.tmo = d >= W;
    e.instr = e.tmo ? 8'h00 : mem[pc];
    e.reqs = e.tmo ? W : d + 1;
    e.start = cyc;
    e.lat = 3 + e.reqs + extra;
    e.ovr = ovr;
    if (push) sb.push_back(e);
    cyc_start = 1;
    err_clr = 1;
    @(posedge clk);
    #1;
    cyc_start = 0;
    err_clr = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("fetch_completed", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_pc_mux", pc_mux, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_req", rom_req, 0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h2A5] = 8'h4C;
    mem[10'h13C] = 8'hC3;
    rst = 1; ena = 1; cyc_start = 0; err_clr = 0; cur_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_reset();
    // basic, wait states, timeout, ack on last cycle
    fetch(10'h2A5, 0, 1, 0, 0); wait_done();
    fetch(10'h0F7, 2, 1, 0, 0); wait_done();
    fetch(10'h3E1, 99, 1, 0, 0); wait_done();
    @(negedge clk); chk("timeout_sticky", timeout_err, 1);
    step(); step();
    @(negedge clk); chk("timeout_sticky_later", timeout_err, 1);
    step(); err_clr = 1; step(); err_clr = 0;
    @(negedge clk); chk("timeout_cleared", timeout_err, 0);
    step();
    fetch(10'h13C, 3, 1, 0, 0); wait_done();
    // overrun during REQ: fetch completes unaltered, no second fetch
    fetch(10'h155, 1, 1, 1, 0);
    step(); step();
    cyc_start = 1; step(); cyc_start = 0;
    wait_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_second_fetch_busy", busy, 0);
      step();
    end
    chk("overrun_sticky", overrun_err, 1);
    // reset while in LO aborts the fetch without a valid
    fetch(10'h2AA, 0, 0, 0, 0);
    step();
    rst = 1; step(); rst = 0;
    check_reset();
    repeat (4) step();
    // ena low for 3 clocks during REQ freezes request and wait count
    fetch(10'h1C7, 99, 1, 0, 3);
    step(); step();
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("req_held_ena_low", rom_req, 1);
      step();
    end
    ena = 1;
    wait_done();
    // random fetches back-to-back or with short gaps
    for (int i = 0; i < 40; i++) begin
      fetch(10'($urandom), $urandom_range(0, 6), 1, 0, 0);
      wait_done();
      repeat ($urandom_range(0, 2)) step();
    end
    @(negedge clk);
    chk("idle_at_end", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
